// File: rtl/conv_loop_addr_gen.sv
// Six-deep conv loop sequencer emitting per-MAC input/weight/output BRAM addresses plus accumulator flags.
// 1-cycle start-to-first-tuple latency; the tuple is held stable while addr_ready is low.
module conv_loop_addr_gen #(
  parameter int ADDR_W   = 14,
  parameter int LANES    = 4,
  parameter int STRIDE_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   do_n,
  input  logic [ADDR_W-1:0]   di_n,
  input  logic [ADDR_W-1:0]   dr,
  input  logic [ADDR_W-1:0]   dc,
  input  logic [ADDR_W-1:0]   dkr,
  input  logic [ADDR_W-1:0]   dkc,
  input  logic [ADDR_W-1:0]   dr_out,
  input  logic [ADDR_W-1:0]   dc_out,
  input  logic [STRIDE_W-1:0] stride,
  input  logic [ADDR_W-1:0]   inaddr,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [ADDR_W-1:0]   outaddr,
  input  logic                addr_ready,
  output logic                addr_valid,
  output logic [ADDR_W-1:0]   in_addr,
  output logic [ADDR_W-1:0]   w_addr,
  output logic [ADDR_W-1:0]   out_addr,
  output logic [ADDR_W-1:0]   w_lane_stride,
  output logic [LANES-1:0]    lane_mask,
  output logic                pixel_first,
  output logic                pixel_last,
  output logic                frame_last,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LANES_A = ADDR_W'(LANES);
  localparam logic [ADDR_W:0]   LANES_X = (ADDR_W+1)'(LANES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] do_n;
    logic [ADDR_W-1:0] di_n;
    logic [ADDR_W-1:0] dr;
    logic [ADDR_W-1:0] dc;
    logic [ADDR_W-1:0] dkr;
    logic [ADDR_W-1:0] dkc;
    logic [ADDR_W-1:0] dr_out;
    logic [ADDR_W-1:0] dc_out;
    logic [ADDR_W-1:0] stride;
    logic [ADDR_W-1:0] inaddr;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] outaddr;
  } cfg_t;

  typedef struct packed {
    logic [ADDR_W-1:0] io;
    logic [ADDR_W-1:0] ir;
    logic [ADDR_W-1:0] ic;
    logic [ADDR_W-1:0] ii;
    logic [ADDR_W-1:0] ikr;
    logic [ADDR_W-1:0] ikc;
  } cnt_t;

  state_t            state;
  cfg_t              cfg_q, cfg_in, cfg_sel;
  cnt_t              cnt_q, cnt_adv, cnt_nxt;
  logic              cfg_bad, hs;
  logic [ADDR_W-1:0] in_nxt, w_nxt, out_nxt, wstride_nxt;
  logic [LANES-1:0]  mask_nxt;
  logic              pf_nxt, pl_nxt, fl_nxt, group_last;

  always_comb begin
    cfg_in.do_n    = do_n;
    cfg_in.di_n    = di_n;
    cfg_in.dr      = dr;
    cfg_in.dc      = dc;
    cfg_in.dkr     = dkr;
    cfg_in.dkc     = dkc;
    cfg_in.dr_out  = dr_out;
    cfg_in.dc_out  = dc_out;
    cfg_in.stride  = ADDR_W'(stride);
    cfg_in.inaddr  = inaddr;
    cfg_in.waddr   = waddr;
    cfg_in.outaddr = outaddr;
    cfg_bad = (do_n == '0) || (di_n == '0) || (dr == '0) || (dc == '0) || (dkr == '0) ||
              (dkc == '0) || (dr_out == '0) || (dc_out == '0) || (stride == '0);
  end

  assign hs = addr_valid & addr_ready;

  // Odometer step, innermost ikc first; only meaningful while a tuple is pending.
  always_comb begin
    cnt_adv = cnt_q;
    if (cnt_q.ikc != cfg_q.dkc - ONE) begin
      cnt_adv.ikc = cnt_q.ikc + ONE;
    end else begin
      cnt_adv.ikc = '0;
      if (cnt_q.ikr != cfg_q.dkr - ONE) begin
        cnt_adv.ikr = cnt_q.ikr + ONE;
      end else begin
        cnt_adv.ikr = '0;
        if (cnt_q.ii != cfg_q.di_n - ONE) begin
          cnt_adv.ii = cnt_q.ii + ONE;
        end else begin
          cnt_adv.ii = '0;
          if (cnt_q.ic != cfg_q.dc_out - ONE) begin
            cnt_adv.ic = cnt_q.ic + ONE;
          end else begin
            cnt_adv.ic = '0;
            if (cnt_q.ir != cfg_q.dr_out - ONE) begin
              cnt_adv.ir = cnt_q.ir + ONE;
            end else begin
              cnt_adv.ir = '0;
              cnt_adv.io = cnt_q.io + LANES_A;
            end
          end
        end
      end
    end
  end

  // At start the first tuple is built straight from the cfg pins with zeroed counters.
  always_comb begin
    cfg_sel = (state == IDLE) ? cfg_in : cfg_q;
    cnt_nxt = (state == IDLE) ? '0 : cnt_adv;
    in_nxt  = cfg_sel.inaddr + ((cnt_nxt.ii * cfg_sel.dr + cnt_nxt.ir * cfg_sel.stride + cnt_nxt.ikr)
              * cfg_sel.dc + cnt_nxt.ic * cfg_sel.stride + cnt_nxt.ikc);
    w_nxt   = cfg_sel.waddr + (((cnt_nxt.io * cfg_sel.di_n + cnt_nxt.ii) * cfg_sel.dkr + cnt_nxt.ikr)
              * cfg_sel.dkc + cnt_nxt.ikc);
    out_nxt = cfg_sel.outaddr + (cnt_nxt.io * cfg_sel.dr_out + cnt_nxt.ir) * cfg_sel.dc_out + cnt_nxt.ic;
    wstride_nxt = cfg_sel.di_n * cfg_sel.dkr * cfg_sel.dkc;
    mask_nxt = '0;
    for (int j = 0; j < LANES; j++) begin
      mask_nxt[j] = ({1'b0, cnt_nxt.io} + (ADDR_W+1)'(j)) < {1'b0, cfg_sel.do_n};
    end
    group_last = ({1'b0, cnt_nxt.io} + LANES_X) >= {1'b0, cfg_sel.do_n};
    pf_nxt = (cnt_nxt.ii == '0) && (cnt_nxt.ikr == '0) && (cnt_nxt.ikc == '0);
    pl_nxt = (cnt_nxt.ii == cfg_sel.di_n - ONE) && (cnt_nxt.ikr == cfg_sel.dkr - ONE) &&
             (cnt_nxt.ikc == cfg_sel.dkc - ONE);
    fl_nxt = pl_nxt && (cnt_nxt.ic == cfg_sel.dc_out - ONE) && (cnt_nxt.ir == cfg_sel.dr_out - ONE) &&
             group_last;
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state         <= IDLE;
      cfg_q         <= '0;
      cnt_q         <= '0;
      addr_valid    <= 1'b0;
      in_addr       <= '0;
      w_addr        <= '0;
      out_addr      <= '0;
      w_lane_stride <= '0;
      lane_mask     <= '0;
      pixel_first   <= 1'b0;
      pixel_last    <= 1'b0;
      frame_last    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              err  <= 1'b1;
              done <= 1'b1;
            end else begin
              state         <= RUN;
              busy          <= 1'b1;
              cfg_q         <= cfg_in;
              cnt_q         <= cnt_nxt;
              w_lane_stride <= wstride_nxt;
              addr_valid    <= 1'b1;
              in_addr       <= in_nxt;
              w_addr        <= w_nxt;
              out_addr      <= out_nxt;
              lane_mask     <= mask_nxt;
              pixel_first   <= pf_nxt;
              pixel_last    <= pl_nxt;
              frame_last    <= fl_nxt;
            end
          end
        end
        RUN: begin
          if (hs) begin
            if (frame_last) begin
              state       <= DONE;
              busy        <= 1'b0;
              done        <= 1'b1;
              addr_valid  <= 1'b0;
              in_addr     <= '0;
              w_addr      <= '0;
              out_addr    <= '0;
              lane_mask   <= '0;
              pixel_first <= 1'b0;
              pixel_last  <= 1'b0;
              frame_last  <= 1'b0;
            end else begin
              cnt_q       <= cnt_nxt;
              in_addr     <= in_nxt;
              w_addr      <= w_nxt;
              out_addr    <= out_nxt;
              lane_mask   <= mask_nxt;
              pixel_first <= pf_nxt;
              pixel_last  <= pl_nxt;
              frame_last  <= fl_nxt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_loop_addr_gen.sv
// Scoreboard bench for conv_loop_addr_gen: nested-loop reference frames queued at start, compared per handshake.
module tb_conv_loop_addr_gen;

  localparam int W = 14;
  localparam int L = 4;

  typedef struct packed {
    logic [W-1:0] ia;
    logic [W-1:0] wa;
    logic [W-1:0] oa;
    logic [L-1:0] m;
    logic         pf;
    logic         pl;
    logic         fl;
  } tup_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [W-1:0] do_n, di_n, dr, dc, dkr, dkc, dr_out, dc_out, inaddr, waddr, outaddr;
  logic [2:0]   stride;
  logic         addr_ready = 1'b1;
  logic         addr_valid, pixel_first, pixel_last, frame_last, busy, done, err;
  logic [W-1:0] in_addr, w_addr, out_addr, w_lane_stride;
  logic [L-1:0] lane_mask;

  conv_loop_addr_gen #(.ADDR_W(W), .LANES(L), .STRIDE_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .do_n(do_n), .di_n(di_n), .dr(dr), .dc(dc), .dkr(dkr), .dkc(dkc),
    .dr_out(dr_out), .dc_out(dc_out), .stride(stride),
    .inaddr(inaddr), .waddr(waddr), .outaddr(outaddr),
    .addr_ready(addr_ready), .addr_valid(addr_valid),
    .in_addr(in_addr), .w_addr(w_addr), .out_addr(out_addr),
    .w_lane_stride(w_lane_stride), .lane_mask(lane_mask),
    .pixel_first(pixel_first), .pixel_last(pixel_last), .frame_last(frame_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  tup_t sb[$];
  int   tuple_cnt, done_cnt, err_cnt, done_cyc, err_cyc, first_cyc, fl_cyc, start_cyc;
  bit   valid_seen, busy_seen, stalled, rand_rdy;
  tup_t first_t, last_t, cap45, held;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference frame built from plain nested loops over the current cfg pins.
  task automatic push_frame();
    tup_t t;
    for (int io = 0; io < int'(do_n); io += L)
      for (int ir = 0; ir < int'(dr_out); ir++)
        for (int ic = 0; ic < int'(dc_out); ic++)
          for (int ii = 0; ii < int'(di_n); ii++)
            for (int kr = 0; kr < int'(dkr); kr++)
              for (int kc = 0; kc < int'(dkc); kc++) begin
                t.ia = inaddr + W'((ir * int'(stride) + kr + ii * int'(dr)) * int'(dc) + ic * int'(stride) + kc);
                t.wa = waddr + W'(io * int'(di_n) * int'(dkr) * int'(dkc) + ii * int'(dkr) * int'(dkc) + kr * int'(dkc) + kc);
                t.oa = outaddr + W'(io * int'(dr_out) * int'(dc_out) + ir * int'(dc_out) + ic);
                for (int j = 0; j < L; j++) t.m[j] = (io + j < int'(do_n));
                t.pf = (ii == 0) && (kr == 0) && (kc == 0);
                t.pl = (ii == int'(di_n) - 1) && (kr == int'(dkr) - 1) && (kc == int'(dkc) - 1);
                t.fl = t.pl && (ir == int'(dr_out) - 1) && (ic == int'(dc_out) - 1) && (io + L >= int'(do_n));
                sb.push_back(t);
              end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    addr_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    tup_t cur;
    cur = '{in_addr, w_addr, out_addr, lane_mask, pixel_first, pixel_last, frame_last};
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (err) begin err_cnt++; err_cyc = cyc; end
    if (busy) busy_seen = 1'b1;
    if (addr_valid) begin
      valid_seen = 1'b1;
      if (stalled) chk("stall_stable", cur, held);
      if (addr_ready) begin
        chk("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) chk($sformatf("tuple%0d", tuple_cnt), cur, sb.pop_front());
        if (tuple_cnt == 0) begin first_t = cur; first_cyc = cyc; end
        if (tuple_cnt == 45) cap45 = cur;
        if (frame_last) fl_cyc = cyc;
        last_t = cur;
        tuple_cnt++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held = cur;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic set_base();
    do_n = 50; di_n = 4; dr = 5; dc = 5; dkr = 5; dkc = 5; dr_out = 1; dc_out = 1;
    stride = 1; inaddr = 2501; waddr = 2601; outaddr = 7601;
  endtask

  task automatic set_stride();
    do_n = 4; di_n = 1; dr = 7; dc = 7; dkr = 3; dkc = 3; dr_out = 3; dc_out = 3;
    stride = 2; inaddr = 0; waddr = 100; outaddr = 200;
  endtask

  task automatic clear_mon();
    tuple_cnt = 0; done_cnt = 0; err_cnt = 0; valid_seen = 0; busy_seen = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input int spur_at);
    push_frame();
    clear_mon();
    pulse_start();
    for (int n = 0; n < 8000 && done_cnt == 0; n++) begin
      @(posedge clk);
      #1;
      start = (n == spur_at);
    end
    start = 1'b0;
    chk("frame_done_seen", done_cnt > 0, 1);
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic wait_tuples(input int n);
    for (int k = 0; k < 8000 && tuple_cnt < n; k++) @(posedge clk);
    #1;
    chk("reach_tuple", tuple_cnt >= n, 1);
  endtask

  initial begin
    set_base();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", addr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done_err", {done, err}, 0);
    chk("rst_wstride", w_lane_stride, 0);
    chk("rst_addr", {in_addr, w_addr, out_addr}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Baseline, ready held high.
    run_frame(-1);
    chk("base_count", tuple_cnt, 1300);
    chk("base_wstride", w_lane_stride, 100);
    chk("base_first_w", first_t.wa, 2601);
    chk("base_last_in", last_t.ia, 2600);
    chk("base_last_w", last_t.wa, 7500);
    chk("base_last_out", last_t.oa, 7649);
    chk("base_last_mask", last_t.m, 4'b0011);
    chk("base_latency", first_cyc - start_cyc, 1);
    chk("base_no_bubbles", fl_cyc - first_cyc, 1299);
    chk("base_done_timing", done_cyc - fl_cyc, 1);
    chk("base_done_once", done_cnt, 1);
    chk("base_err", err_cnt, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("base_idle_busy", busy, 0);

    // Stride geometry with a stray start mid-frame.
    set_stride();
    run_frame(20);
    chk("stride_count", tuple_cnt, 81);
    chk("stride_in45", cap45.ia, 18);
    chk("stride_pf45", cap45.pf, 1);
    chk("stride_done_once", done_cnt, 1);
    repeat (3) @(posedge clk);

    // Random backpressure on the baseline frame.
    set_base();
    rand_rdy = 1'b1;
    run_frame(-1);
    rand_rdy = 1'b0;
    chk("bp_count", tuple_cnt, 1300);
    chk("bp_done_once", done_cnt, 1);
    repeat (3) @(posedge clk);

    // Zero kernel columns is rejected.
    dkc = 0;
    clear_mon();
    pulse_start();
    repeat (5) @(posedge clk);
    #1;
    chk("bad_err", err_cnt, 1);
    chk("bad_done", done_cnt, 1);
    chk("bad_same_cycle", err_cyc == done_cyc, 1);
    chk("bad_no_valid", valid_seen, 0);
    chk("bad_no_busy", busy_seen, 0);

    // Abort at tuple 600, then a clean rerun.
    set_base();
    push_frame();
    clear_mon();
    pulse_start();
    wait_tuples(600);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("abort_valid", addr_valid, 0);
    chk("abort_busy", busy, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, 0);
    run_frame(-1);
    chk("rerun_count", tuple_cnt, 1300);
    chk("rerun_first_w", first_t.wa, 2601);
    chk("rerun_first_in", first_t.ia, 2501);
    repeat (3) @(posedge clk);

    // Synchronous reset mid-frame.
    set_stride();
    push_frame();
    clear_mon();
    pulse_start();
    wait_tuples(30);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("rst_mid_valid", addr_valid, 0);
    chk("rst_mid_busy", busy, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("rst_mid_no_done", done_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
